rev_gate_sequencer: RTL
=======================

// Module: rev_gate_sequencer
// PURPOSE
//  Sequences a stored program of reversible gates (NOT, Toffoli, Fredkin/controlled-swap) over an
//  NBITS-wide qubit-style bit register, one gate per clock. Replaces hard-wired gate netlists
//  with a single time-shared gate datapath. Runs the program forward or in reverse
//  (uncompute). All gates are self-inverse, so a reverse run restores the forward-run input.
// PARAMETERS
//  NBITS  4   width of working bit register; IDXW = $clog2(NBITS) (min 1)
//  DEPTH  8   program memory entries; AW = $clog2(DEPTH) (min 1)
//  INSTR_W = 2+3*IDXW (derived; not overridable)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous, active-low reset
//  prog_we     in   1        program write strobe; honoured only in IDLE
//  prog_addr   in   AW       program write address
//  prog_wdata  in   INSTR_W  {op[1:0], f2, f1, f0}, each f* is IDXW bits
//  start       in   1        start request; sampled only in IDLE
//  reverse     in   1        sampled with start: 0 = pc 0..len-1, 1 = pc len-1..0
//  len         in   AW+1     gate count, sampled with start; values > DEPTH are clamped to DEPTH
//  data_in     in   NBITS    initial register value, sampled with start
//  busy        out  1        high in RUN and DONE
//  done        out  1        one-cycle pulse; data_out valid from this cycle
//  data_out    out  NBITS    working register; holds its value until the next accepted start
//  err         out  1        sticky; set by an illegal gate; cleared by an accepted start
// BEHAVIOUR
//  Reset (async): FSM=IDLE; busy=0, done=0, err=0, data_out=0, pc=0; all program entries=0 (NOP).
//  Opcodes (f0/f1/f2 are bit indices into register q):
//   00 NOP     : no change
//   01 NOT     : q[f0] ^= 1 (f1, f2 ignored)
//   10 TOFFOLI : q[f2] ^= q[f0] & q[f1]
//   11 FREDKIN : if q[f2], swap q[f0] and q[f1]
//  Illegal gate (executes as NOP and sets err):
//   - any used index >= NBITS;
//   - used indices not pairwise distinct (Toffoli, Fredkin).
//  FSM:
//   IDLE -> RUN when start:
//    - q <= data_in; err <= 0;
//    - pc <= reverse ? len-1 : 0; remaining <= len;
//    - if len == 0, go to DONE instead.
//   RUN: each cycle
//    - apply prog[pc] to q;
//    - step pc +1 (forward) or -1 (reverse); remaining -= 1;
//    - after the last gate is applied, go to DONE. pc never wraps.
//   DONE: done=1 for exactly one cycle, then IDLE.
//  Latency:
//   - start sampled at edge E0; done is high in the cycle after edge E0+len;
//   - len=0 gives done one cycle after start, with data_out=data_in.
//  Conflicts and corner cases:
//   - start while busy is ignored;
//   - prog_we while busy is ignored (the program is stable during a run);
//   - prog_we and start in the same IDLE cycle: the write commits, and the run uses the new entry.
//  Reset mid-run: the run is aborted and all state returns to reset values (program is cleared).
// TESTING
//  T1 NBITS=4: program NOT(0); TOFFOLI(0,1->2); FREDKIN(1,3 ctl 2); len=3, fwd, data_in=4'b0010
//     -> done 4 cycles after start, data_out=4'b1101, err=0.
//  T2 same program, reverse=1, data_in=4'b1101 -> data_out=4'b0010, done after 4 cycles.
//  T3 len=0, data_in=4'b1010 -> done on next cycle, data_out=4'b1010, busy high for 1 cycle.
//  T4 TOFFOLI(1,1->2) at entry 0, len=1, data_in=4'b0110 -> err=1, data_out=4'b0110.
//     Then a fresh start clears err.
//  T5 during a 3-gate run:
//     - pulse start with different data_in and prog_we to entry 0;
//     - both are ignored, and the result matches T1.
//  T6 assert rst_n=0 during the 2nd RUN cycle
//     -> busy/done/err/data_out=0 immediately; program reads back as NOP (len=1 run: data unchanged).

Source files
------------

// File: rtl/rev_gate_sequencer.sv
// -----------------------------------------------------------------------------
// rev_gate_sequencer
//   Time-shared reversible gate engine. A small program memory holds gates
//   (NOP, NOT, Toffoli, Fredkin). One gate is applied per clock to an
//   NBITS-wide working register. The program runs forward (pc 0..len-1) or in
//   reverse (pc len-1..0). Every gate is self-inverse, so a reverse run undoes
//   a forward run.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   prog_we      program write strobe (accepted only while idle)
//   prog_addr    program write address
//   prog_wdata   instruction {op[1:0], f2, f1, f0}
//   start        run request (accepted only while idle)
//   reverse      run direction, sampled with start
//   len          gate count, sampled with start, clamped to DEPTH
//   data_in      initial register value, sampled with start
//   busy         high while running and during the done cycle
//   done         one-cycle completion pulse
//   data_out     working register, held until the next accepted start
//   err          sticky illegal-gate flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module rev_gate_sequencer #(
  parameter  int NBITS   = 4,
  parameter  int DEPTH   = 8,
  localparam int IDXW    = (NBITS > 1) ? $clog2(NBITS) : 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int INSTR_W = 2 + 3 * IDXW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               start,
  input  logic               reverse,
  input  logic [AW:0]        len,
  input  logic [NBITS-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [NBITS-1:0]   data_out,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_NOT  = 2'b01,
    OP_TOF  = 2'b10,
    OP_FRED = 2'b11
  } op_e;

  state_e state_q, state_d;

  logic [INSTR_W-1:0] prog [DEPTH];
  logic [NBITS-1:0]   q_q;
  logic               err_q;
  logic [AW-1:0]      pc_q;
  logic [AW:0]        remaining_q;
  logic               rev_q;

  logic               run_accept;
  logic [AW:0]        len_clamped;
  logic [AW-1:0]      pc_last;
  logic               last_gate;

  logic [INSTR_W-1:0] instr;
  op_e                op;
  logic [IDXW-1:0]    f0, f1, f2;
  logic               ok0, ok3;
  logic [NBITS-1:0]   q_gate;
  logic               gate_err;

  function automatic logic idx_ok(input logic [IDXW-1:0] f);
    return 32'(f) < NBITS;
  endfunction

  assign len_clamped = (32'(len) > DEPTH) ? (AW+1)'(DEPTH) : len;
  assign pc_last     = AW'(len_clamped - (AW+1)'(1));
  assign last_gate   = (remaining_q == (AW+1)'(1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    run_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          run_accept = 1'b1;
          state_d    = (len_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (last_gate) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program memory: writable only while idle so a run sees a stable program.
  // A write in the same cycle as an accepted start commits before the first
  // gate is fetched, so the run uses the new entry.
  // ---------------------------------------------------------------------------
  // NOTE: the program store is reset explicitly (to NOP) because a reset must
  // leave a defined program; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) prog[i] <= '0;
    end else if (prog_we && state_q == S_IDLE && 32'(prog_addr) < DEPTH) begin
      prog[prog_addr] <= prog_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate datapath: decode prog[pc] and apply it to the working register.
  // Illegal gates leave the register untouched and raise gate_err.
  // ---------------------------------------------------------------------------
  assign instr = prog[pc_q];
  assign op    = op_e'(instr[INSTR_W-1 -: 2]);
  assign f2    = instr[3*IDXW-1 -: IDXW];
  assign f1    = instr[2*IDXW-1 -: IDXW];
  assign f0    = instr[IDXW-1:0];
  assign ok0   = idx_ok(f0);
  assign ok3   = idx_ok(f0) && idx_ok(f1) && idx_ok(f2) &&
                 (f0 != f1) && (f0 != f2) && (f1 != f2);

  always_comb begin
    q_gate   = q_q;
    gate_err = 1'b0;
    case (op)
      OP_NOP: ;
      OP_NOT: begin
        if (ok0) q_gate[f0] = ~q_q[f0];
        else     gate_err   = 1'b1;
      end
      OP_TOF: begin
        if (ok3) q_gate[f2] = q_q[f2] ^ (q_q[f0] & q_q[f1]);
        else     gate_err   = 1'b1;
      end
      OP_FRED: begin
        if (!ok3) begin
          gate_err = 1'b1;
        end else if (q_q[f2]) begin
          q_gate[f0] = q_q[f1];
          q_gate[f1] = q_q[f0];
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run control registers. pc only steps while more gates remain, so it
  // never wraps past either end of the program.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      err_q       <= 1'b0;
      pc_q        <= '0;
      remaining_q <= '0;
      rev_q       <= 1'b0;
    end else if (run_accept) begin
      q_q         <= data_in;
      err_q       <= 1'b0;
      rev_q       <= reverse;
      remaining_q <= len_clamped;
      pc_q        <= (reverse && len_clamped != '0) ? pc_last : '0;
    end else if (state_q == S_RUN) begin
      q_q         <= q_gate;
      err_q       <= err_q | gate_err;
      remaining_q <= remaining_q - (AW+1)'(1);
      if (!last_gate) pc_q <= rev_q ? pc_q - AW'(1) : pc_q + AW'(1);
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign data_out = q_q;
  assign err      = err_q;

endmodule
